// File: rtl/breakout_pkg.sv
// breakout_pkg: state codes and widths shared by the game controller and the renderer
package breakout_pkg;
  localparam int STATE_W = 3;
  typedef enum logic [STATE_W-1:0] {
    ATTRACT   = 3'd0,
    COUNTDOWN = 3'd1,
    PLAY      = 3'd2,
    PAUSED    = 3'd3,
    OVER      = 3'd4,
    WIN       = 3'd5
  } state_t;
endpackage

// File: rtl/breakout_tick_gen.sv
// breakout_tick_gen: clearable divider emitting a 1-cycle tick every TERM enabled cycles
module breakout_tick_gen #(
  parameter int unsigned TERM = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int W = TERM > 1 ? $clog2(TERM) : 1;
  logic [W-1:0] cnt;
  assign tick = en && cnt == W'(TERM - 1);
  always_ff @(posedge clk)
    cnt <= (rst || clr || tick) ? '0 : en ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/breakout_game_ctrl.sv
// breakout_game_ctrl: attract/countdown/play/pause/over/win sequencing and high-score tracking
module breakout_game_ctrl
  import breakout_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned COUNT_SECS  = 3,
  parameter int unsigned HOLD_MS     = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               touch_pressed,
  input  logic               pause_pulse,
  input  logic               ball_lost,
  input  logic [47:0]        bricks_alive,
  input  logic [9:0]         score,
  output logic               game_run,
  output logic               new_game,
  output logic [STATE_W-1:0] game_state,
  output logic [1:0]         countdown,
  output logic [9:0]         high_score
);
  localparam int unsigned HOLD_CYC = CLK_FREQ_HZ / 1000 * HOLD_MS;
  state_t state, nxt;
  logic touch_q, hold_done, sec_tick, hold_tick, tap, accept, ending;
  assign tap = touch_pressed && !touch_q;
  assign accept = tap && (state == ATTRACT || ((state == OVER || state == WIN) && hold_done));
  assign ending = state == PLAY && (nxt == OVER || nxt == WIN);
  assign game_state = state;
  breakout_tick_gen #(.TERM(CLK_FREQ_HZ)) u_sec (
    .clk(clk), .rst(reset), .clr(accept), .en(state == COUNTDOWN), .tick(sec_tick)
  );
  // Held in clear throughout PLAY so the dwell starts fresh on the entry edge
  breakout_tick_gen #(.TERM(HOLD_CYC)) u_hold (
    .clk(clk), .rst(reset), .clr(state == PLAY),
    .en((state == OVER || state == WIN) && !hold_done), .tick(hold_tick)
  );
  always_comb begin
    nxt = ATTRACT;
    case (state)
      ATTRACT:   nxt = accept ? COUNTDOWN : ATTRACT;
      COUNTDOWN: nxt = (sec_tick && countdown == 2'd1) ? PLAY : COUNTDOWN;
      PLAY:      nxt = ball_lost ? OVER : bricks_alive == '0 ? WIN : pause_pulse ? PAUSED : PLAY;
      PAUSED:    nxt = (pause_pulse || tap) ? PLAY : PAUSED;
      OVER:      nxt = accept ? COUNTDOWN : OVER;
      WIN:       nxt = accept ? COUNTDOWN : WIN;
      default:   nxt = ATTRACT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ATTRACT;
      touch_q    <= 1'b1;
      game_run   <= 1'b0;
      new_game   <= 1'b0;
      countdown  <= 2'd0;
      high_score <= 10'd0;
      hold_done  <= 1'b0;
    end else begin
      state     <= nxt;
      touch_q   <= touch_pressed;
      game_run  <= state == PLAY;
      new_game  <= accept;
      countdown <= accept ? 2'(COUNT_SECS) : (state == COUNTDOWN && sec_tick) ? countdown - 2'd1 : countdown;
      hold_done <= state == PLAY ? 1'b0 : hold_tick ? 1'b1 : hold_done;
      if (ending && score > high_score) high_score <= score;
    end
  end
endmodule
